// File: rtl/ssp_pkg.sv
// Shared types and defaults for the SSP transmit path.
package ssp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SYNC,
        SHIFT
    } ssp_tx_state_e;

    localparam int SSP_DATA_W_DEF  = 8;
    localparam int SSP_CLK_DIV_DEF = 2;

endpackage

// File: rtl/ssp_clk_gen.sv
// SSP bit-clock divider: one bit period is 2*CLK_DIV clk_i cycles, ssp_clk high in the first half.
// start_i restarts a bit period (clock high next cycle); run_i low parks the clock low.
module ssp_clk_gen
    import ssp_pkg::*;
#(
    parameter int CLK_DIV = SSP_CLK_DIV_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic run_i,
    output logic rise_tick_o,
    output logic fall_tick_o,
    output logic end_tick_o,
    output logic ssp_clk_o
);

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          clk_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else if (start_i) begin
            cnt_q <= '0;
            clk_q <= 1'b1;
        end else if (!run_i) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            clk_q <= ~clk_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Ticks qualify the current cycle: first cycle of each half, last cycle of the period.
    assign rise_tick_o = clk_q & (cnt_q == '0);
    assign fall_tick_o = ~clk_q & (cnt_q == '0);
    assign end_tick_o  = ~clk_q & (cnt_q == CNT_MAX);
    assign ssp_clk_o   = clk_q;

endmodule

// File: rtl/ssp_tx_serializer.sv
// SSP transmitter: pops bytes from the TX FIFO and sends TI-style frames (FSS period, then MSB-first data).
// Define SSP_TX_BACK2BACK_EN to prefetch during the last bit and chain frames with no idle gap.
module ssp_tx_serializer
    import ssp_pkg::*;
#(
    parameter int DATA_W  = SSP_DATA_W_DEF,
    parameter int CLK_DIV = SSP_CLK_DIV_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              fifo_empty_i,
    output logic              fifo_read_o,
    input  logic [DATA_W-1:0] fifo_rd_data_i,
    output logic              ssp_clk_o,
    output logic              ssp_fss_o,
    output logic              ssp_txd_o,
    output logic              busy_o
);

    localparam int BW = $clog2(DATA_W);

    ssp_tx_state_e     state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [BW-1:0]     bit_cnt_q;
    logic              fss_q, txd_q, busy_q, armed_q;

    logic rise_tick, fall_tick, end_tick;
    logic can_pop, idle_pop, b2b_pop, last_bit, frame_end, chain, run;
    logic unused_ticks;

    // armed_q keeps the pop strobe quiet while reset is held and for the first cycle after release.
    assign can_pop   = armed_q & enable_i & ~fifo_empty_i;
    assign idle_pop  = (state_q == IDLE) & can_pop;
    assign last_bit  = (state_q == SHIFT) && (bit_cnt_q == '0);
    assign frame_end = last_bit & end_tick;

`ifdef SSP_TX_BACK2BACK_EN
    logic pend_q;

    assign b2b_pop = last_bit & rise_tick & can_pop & ~pend_q;
    assign chain   = pend_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        pend_q <= 1'b0;
        else if (b2b_pop)   pend_q <= 1'b1;
        else if (frame_end) pend_q <= 1'b0;
    end
`else
    assign b2b_pop = 1'b0;
    assign chain   = 1'b0;
`endif

    assign fifo_read_o  = idle_pop | b2b_pop;
    assign run          = ((state_q == SYNC) || (state_q == SHIFT)) && !(frame_end && !chain);
    assign unused_ticks = fall_tick ^ rise_tick;

    ssp_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (state_q == FETCH),
        .run_i       (run),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick),
        .end_tick_o  (end_tick),
        .ssp_clk_o   (ssp_clk_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            fss_q     <= 1'b0;
            txd_q     <= 1'b0;
            busy_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (idle_pop) begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    shreg_q <= fifo_rd_data_i;
                    state_q <= SYNC;
                    fss_q   <= 1'b1;
                    txd_q   <= 1'b0;
                end
                SYNC: begin
                    if (end_tick) begin
                        state_q   <= SHIFT;
                        fss_q     <= 1'b0;
                        txd_q     <= shreg_q[DATA_W-1];
                        bit_cnt_q <= BW'(DATA_W - 1);
                    end
                end
                SHIFT: begin
                    if (end_tick) begin
                        if (bit_cnt_q != '0) begin
                            // Outputs are registered, so present the next bit as it shifts in.
                            shreg_q   <= shreg_q << 1;
                            txd_q     <= shreg_q[DATA_W-2];
                            bit_cnt_q <= bit_cnt_q - 1'b1;
                        end else if (chain) begin
                            shreg_q <= fifo_rd_data_i;
                            state_q <= SYNC;
                            fss_q   <= 1'b1;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            txd_q   <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ssp_fss_o = fss_q;
    assign ssp_txd_o = txd_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_ssp_tx_serializer.sv
// Directed bench for ssp_tx_serializer: FIFO model, frame decoder and byte scoreboard.
module tb_ssp_tx_serializer;

    localparam int T  = 4;
    localparam int NB = 8;
    localparam int FRAME = (NB + 1) * T;

    logic       clk = 1'b0;
    logic       rst_ni, enable, fifo_empty, fifo_read;
    logic [7:0] rd_data;
    logic       ssp_clk, ssp_fss, ssp_txd, busy;
    logic       wr_en;
    logic [7:0] wr_data;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    int n_chk = 0, n_err = 0;
    int cyc = 0, frames = 0, pops = 0, bad_pop = 0, idle_bad = 0;
    int fc = 0, shape_bad = 0, start_cyc = 0, end_cyc = 0, last_gap = -1;
    int pop_fc = -1, busy_run = 0, busy_len = 0;
    bit in_frame = 0;
    logic [7:0] rx, exp_b;
    logic cur_bit;

    always #5 clk = ~clk;

    ssp_tx_serializer dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .enable_i       (enable),
        .fifo_empty_i   (fifo_empty),
        .fifo_read_o    (fifo_read),
        .fifo_rd_data_i (rd_data),
        .ssp_clk_o      (ssp_clk),
        .ssp_fss_o      (ssp_fss),
        .ssp_txd_o      (ssp_txd),
        .busy_o         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO with registered read data that holds until the next pop.
    initial begin
        fifo_empty = 1'b1;
        rd_data    = 8'h00;
    end
    always @(posedge clk) begin
        if (fifo_read && fifo_q.size() > 0) rd_data <= fifo_q.pop_front();
        if (wr_en) fifo_q.push_back(wr_data);
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = b;
        exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Frame decoder: expected waveform is derived from the frame-relative cycle index.
    always @(negedge clk) begin
        cyc++;
        if (!rst_ni) begin
            in_frame = 0;
            busy_run = 0;
        end else begin
            if (fifo_read) begin
                pops++;
                if (fifo_empty) bad_pop++;
                pop_fc = in_frame ? fc : -1;
            end
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                busy_len = busy_run;
                busy_run = 0;
            end
            if (!in_frame && ssp_fss) begin
                in_frame = 1;
                fc = 0;
                rx = 8'h00;
                shape_bad = 0;
                start_cyc = cyc;
                last_gap = (frames > 0) ? start_cyc - end_cyc - 1 : -1;
                exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            end
            if (in_frame) begin
                if (ssp_clk !== ((fc % T) < T / 2)) shape_bad++;
                if (ssp_fss !== (fc < T)) shape_bad++;
                if (fc % T == 0) cur_bit = ssp_txd;
                else if (ssp_txd !== cur_bit) shape_bad++;
                if (fc < T) begin
                    if (ssp_txd !== 1'b0) shape_bad++;
                end else if (fc % T == T / 2) begin
                    rx = {rx[6:0], ssp_txd};
                end
                fc++;
                if (fc == FRAME) begin
                    in_frame = 0;
                    frames++;
                    end_cyc = cyc;
                    chk("frame_data", rx, exp_b);
                    chk("frame_shape", shape_bad, 0);
                end
            end else if (ssp_clk || ssp_fss || ssp_txd) begin
                idle_bad++;
            end
        end
    end

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("frame_timeout", frames >= n, 1);
    endtask

    task automatic wait_fc(input int n, input int budget);
        int k = 0;
        while (!(in_frame && fc >= n) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("bit_timeout", in_frame && fc >= n, 1);
    endtask

    initial begin
        int f0, p0;
        logic rd_in_rst, clk_seen;
        rst_ni = 1'b0;
        enable = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;

        // Reset held with a byte waiting: nothing may move.
        repeat (2) @(negedge clk);
        push(8'hA5);
        rd_in_rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            rd_in_rst |= fifo_read;
        end
        chk("rst_outputs", {ssp_clk, ssp_fss, ssp_txd, busy}, 0);
        chk("rst_no_pop", rd_in_rst, 0);
        rst_ni = 1'b1;
        #1 chk("release_no_pop", fifo_read, 0);
        @(negedge clk);
        chk("release_pop", fifo_read, 1);
        wait_frames(1, 200);
        repeat (3) @(negedge clk);
        chk("busy_len", busy_len, 1 + FRAME);

        // Two queued bytes: gap and pop placement depend on the build.
        f0 = frames;
        p0 = pops;
        push(8'h3C);
        push(8'hC3);
        wait_frames(f0 + 2, 300);
        repeat (3) @(negedge clk);
        chk("two_byte_pops", pops - p0, 2);
`ifdef SSP_TX_BACK2BACK_EN
        chk("b2b_gap", last_gap, 0);
        chk("b2b_pop_phase", pop_fc, FRAME - T);
`else
        chk("idle_gap", last_gap, 2);
        chk("idle_pop_phase", pop_fc, -1);
`endif

        // Enable dropped mid-frame: frame completes, second byte stays queued.
        f0 = frames;
        p0 = pops;
        push(8'h5A);
        push(8'h96);
        wait_fc(10, 100);
        enable = 1'b0;
        wait_frames(f0 + 1, 200);
        repeat (50) @(negedge clk);
        chk("en_off_busy", busy, 0);
        chk("en_off_pops", pops - p0, 1);
        enable = 1'b1;
        wait_frames(f0 + 2, 200);
        repeat (3) @(negedge clk);

        // Async reset during bit 3 of 0xFF: that byte is lost, the next goes out whole.
        f0 = frames;
        push(8'hFF);
        push(8'h81);
        wait_fc(T + 3 * T + 2, 200);
        #1 rst_ni = 1'b0;
        #1 chk("arst_outputs", {ssp_clk, ssp_fss, ssp_txd, busy}, 0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        wait_frames(f0 + 1, 200);
        repeat (3) @(negedge clk);
        chk("arst_sb_empty", exp_q.size(), 0);

        // Empty FIFO with enable high: no pops, clock parked low.
        p0 = pops;
        clk_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            clk_seen |= ssp_clk;
        end
        chk("empty_clk_low", clk_seen, 0);
        chk("empty_no_pop", pops - p0, 0);

        chk("pop_while_empty", bad_pop, 0);
        chk("idle_outputs", idle_bad, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
